// File: rtl/fusion_result_sink.sv
`default_nettype none
// ============================================================================
// Module      : fusion_result_sink
// Description : Stream-slave endpoint for the fusion pipeline result stream.
//               Unpacks each 32-bit beat {16'h0, average, fused} into a
//               16-bit pixel record and writes it into a ping-pong frame
//               buffer through a stallable write port. Checks frame length
//               against s_axis_last and reports per-frame status.
// Ports       :
//   axi_clk       in   sole clock, rising edge
//   axi_reset_n   in   asynchronous active-low reset
//   enable        in   arms reception (sampled in IDLE and DONE only)
//   s_axis_valid  in   beat valid
//   s_axis_input  in   beat data: [7:0] fused, [15:8] average, rest ignored
//   s_axis_last   in   final beat of frame
//   s_axis_ready  out  beat accept
//   wr_en         out  write request (held until wr_ready)
//   wr_addr       out  buffer address (buf_sel*N + pixel index)
//   wr_data       out  {average, fused}
//   wr_ready      in   write-port accept
//   frame_done    out  one-cycle pulse per terminated frame
//   frame_err     out  [0] short frame, [1] long frame (most recent frame)
//   buf_sel       out  buffer currently being filled
//   frame_count   out  count of good frames, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module fusion_result_sink #(
    parameter int IM_LEN           = 520,
    parameter int IM_WID           = 520,
    parameter int INPUT_DATA_WIDTH = 32,
    parameter int ADDR_W           = 20,
    parameter int CNT_W            = 16
) (
    input  logic                        axi_clk,
    input  logic                        axi_reset_n,
    input  logic                        enable,
    input  logic                        s_axis_valid,
    input  logic [INPUT_DATA_WIDTH-1:0] s_axis_input,
    input  logic                        s_axis_last,
    output logic                        s_axis_ready,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [15:0]                 wr_data,
    input  logic                        wr_ready,
    output logic                        frame_done,
    output logic [1:0]                  frame_err,
    output logic                        buf_sel,
    output logic [CNT_W-1:0]            frame_count
);

    localparam logic [ADDR_W-1:0] c_N    = ADDR_W'(IM_LEN * IM_WID);
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(IM_LEN * IM_WID - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pix_idx;
    logic [1:0]        r_err_pend;   // status of the frame being terminated

    logic              w_wr_free;    // write register empty or completing now
    logic              w_accept;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_unused_hi;

    // Upper half of the beat carries no information.
    assign w_unused_hi = ^s_axis_input[INPUT_DATA_WIDTH-1:16];

    assign w_wr_free    = !wr_en || wr_ready;
    assign s_axis_ready = ((r_state == S_RECV) || (r_state == S_DRAIN)) && w_wr_free;
    assign w_accept     = s_axis_valid && s_axis_ready;
    assign w_wr_addr    = (buf_sel ? c_N : '0) + r_pix_idx;

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_state     <= S_IDLE;
            r_pix_idx   <= '0;
            r_err_pend  <= 2'b00;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 2'b00;
            buf_sel     <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;

            // Write register: a new load always wins; otherwise the pending
            // write is retired once the port accepts it.
            if (r_state == S_RECV && w_accept) begin
                wr_en   <= 1'b1;
                wr_addr <= w_wr_addr;
                wr_data <= s_axis_input[15:0];
            end else if (wr_en && wr_ready) begin
                wr_en <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state   <= S_RECV;
                        r_pix_idx <= '0;
                    end
                end

                S_RECV: begin
                    if (w_accept) begin
                        r_pix_idx <= r_pix_idx + ADDR_W'(1);
                        if (s_axis_last) begin
                            r_err_pend <= (r_pix_idx == c_LAST) ? 2'b00 : 2'b01;
                            r_state    <= S_DONE;
                        end else if (r_pix_idx == c_LAST) begin
                            // Frame overran its nominal size: swallow the rest.
                            r_err_pend <= 2'b10;
                            r_state    <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (w_accept && s_axis_last) begin
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Report only once the final write has left (or is
                    // leaving on this edge), so downstream never sees
                    // frame_done ahead of the data.
                    if (w_wr_free) begin
                        frame_done <= 1'b1;
                        frame_err  <= r_err_pend;
                        if (r_err_pend == 2'b00) begin
                            buf_sel     <= ~buf_sel;
                            frame_count <= frame_count + CNT_W'(1);
                        end
                        r_pix_idx <= '0;
                        r_state   <= enable ? S_RECV : S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fusion_result_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_fusion_result_sink
// Description : Self-checking bench for fusion_result_sink (N = 4x4 = 16).
//               Expected writes are queued as beats are driven and compared
//               as the write port retires them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fusion_result_sink;

    localparam int N      = 16;
    localparam int ADDR_W = 20;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              s_valid = 1'b0;
    logic [31:0]       s_data = '0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              wr_ready = 1'b1;
    logic              frame_done;
    logic [1:0]        frame_err;
    logic              buf_sel;
    logic [CNT_W-1:0]  frame_count;

    logic              bp_mode = 1'b0;
    int                n_tests = 0;
    int                n_fail = 0;
    int                wr_count = 0;
    int                exp_buf = 0;
    int                exp_cnt = 0;
    logic [35:0]       sb[$];
    logic [35:0]       mon_e;

    fusion_result_sink #(
        .IM_LEN           (4),
        .IM_WID           (4),
        .INPUT_DATA_WIDTH (32),
        .ADDR_W           (ADDR_W),
        .CNT_W            (CNT_W)
    ) dut (
        .axi_clk      (clk),
        .axi_reset_n  (rst_n),
        .enable       (enable),
        .s_axis_valid (s_valid),
        .s_axis_input (s_data),
        .s_axis_last  (s_last),
        .s_axis_ready (s_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .buf_sel      (buf_sel),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write-port acceptor: always ready, or the 1,0,0,1 stall pattern.
    initial begin
        int         cyc;
        logic [3:0] pat;
        cyc = 0;
        pat = 4'b1001;
        forever begin
            @(posedge clk);
            #1;
            wr_ready = bp_mode ? pat[cyc[1:0]] : 1'b1;
            cyc++;
        end
    end

    // Write monitor: every retired write is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en && !wr_ready)
                check("ready_during_stall", {31'd0, s_ready}, 32'd0);
            if (wr_en && wr_ready) begin
                wr_count++;
                check("sb_has_entry", {31'd0, (sb.size() != 0)}, 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("wr_addr", {12'd0, wr_addr}, {12'd0, mon_e[35:16]});
                    check("wr_data", {16'd0, wr_data}, {16'd0, mon_e[15:0]});
                end
            end
        end
    end

    task automatic wait_accept();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_ready) break;
        end
        check("accept_in_time", {31'd0, (k < 100)}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int nbeats);
        int         k;
        logic [1:0] e_err;
        int         e_wr;
        e_err = (nbeats == N) ? 2'b00 : ((nbeats < N) ? 2'b01 : 2'b10);
        e_wr  = (nbeats < N) ? nbeats : N;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        check("frame_done_seen", {31'd0, frame_done}, 32'd1);
        if (e_err == 2'b00) begin
            exp_buf = exp_buf ^ 1;
            exp_cnt++;
        end
        check("frame_err", {30'd0, frame_err}, {30'd0, e_err});
        check("buf_sel", {31'd0, buf_sel}, 32'(exp_buf));
        check("frame_count", {16'd0, frame_count}, 32'(exp_cnt));
        check("write_count", 32'(wr_count), 32'(e_wr));
        check("writes_done_before_frame_done", 32'(sb.size()), 32'd0);
        @(negedge clk);
        check("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);
        check("frame_err_hold", {30'd0, frame_err}, {30'd0, e_err});
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int nbeats, input logic [15:0] upper,
                              input logic [15:0] base, input logic bp);
        logic [15:0] d;
        bp_mode  = bp;
        wr_count = 0;
        for (int i = 0; i < nbeats; i++) begin
            d       = base + 16'(i);
            s_data  = {upper, d};
            s_last  = (i == nbeats - 1);
            s_valid = 1'b1;
            if (i < N)
                sb.push_back({20'(exp_buf * N + i), d});
            wait_accept();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_done(nbeats);
        bp_mode = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},    {31'd0, s_ready},     32'd0);
        check({tag, "_wr_en"},    {31'd0, wr_en},       32'd0);
        check({tag, "_wr_addr"},  {12'd0, wr_addr},     32'd0);
        check({tag, "_wr_data"},  {16'd0, wr_data},     32'd0);
        check({tag, "_done"},     {31'd0, frame_done},  32'd0);
        check({tag, "_err"},      {30'd0, frame_err},   32'd0);
        check({tag, "_buf_sel"},  {31'd0, buf_sel},     32'd0);
        check({tag, "_count"},    {16'd0, frame_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ready_low", {31'd0, s_ready}, 32'd0);
        enable = 1'b1;

        send_frame(16, 16'h0000, 16'hA0B0, 1'b0);   // good, buffer 0
        send_frame(16, 16'h5A5A, 16'hC000, 1'b0);   // good, buffer 1, junk upper bits
        send_frame(16, 16'hFFFF, 16'h1230, 1'b1);   // good under backpressure
        send_frame(10, 16'h0000, 16'h4400, 1'b0);   // short frame
        send_frame(20, 16'h0000, 16'h5500, 1'b1);   // long frame, backpressure
        send_frame(16, 16'h0000, 16'h6600, 1'b0);   // good, rewrites same buffer

        // Abort a frame with reset after 5 beats.
        for (int i = 0; i < 5; i++) begin
            s_data  = 32'h0000_8800 + 32'(i);
            s_last  = 1'b0;
            s_valid = 1'b1;
            sb.push_back({20'(exp_buf * N + i), 16'h8800 + 16'(i)});
            wait_accept();
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        s_valid = 1'b0;
        sb.delete();
        exp_buf = 0;
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(16, 16'h0000, 16'h7700, 1'b0);   // restarts at address 0

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
